// File: rtl/mips_run_ctrl.sv
// Run controller for the pipelined mips core: stretches reset, counts run cycles,
// and ends the run on a PC dead loop (halt) or an exhausted cycle budget (timeout).
module mips_run_ctrl #(
    parameter int unsigned PC_W        = 32,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned RST_CYCLES  = 2,
    parameter int unsigned MAX_CYCLES  = 100000,
    parameter int unsigned STALL_LIMIT = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [PC_W-1:0]  pc_i,
    output logic             core_reset,
    output logic             running,
    output logic             done,
    output logic             halted,
    output logic             timed_out,
    output logic [CNT_W-1:0] cycle_cnt
);

    localparam int unsigned HOLD_W  = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam int unsigned STALL_W = $clog2(STALL_LIMIT + 1);

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RST_CYCLES - 1);
    localparam logic [CNT_W-1:0]   CYC_LAST   = CNT_W'(MAX_CYCLES);
    localparam logic [STALL_W-1:0] STALL_LAST = STALL_W'(STALL_LIMIT);

    typedef enum logic [1:0] {
        RST_HOLD = 2'd0,
        RUN      = 2'd1,
        DONE     = 2'd2
    } state_t;

    state_t             state, state_d;
    logic [HOLD_W-1:0]  hold_cnt, hold_cnt_d;
    logic [STALL_W-1:0] stall_cnt, stall_cnt_d;
    logic [PC_W-1:0]    pc_prev, pc_prev_d;
    logic               pc_valid, pc_valid_d;
    logic [CNT_W-1:0]   cycle_cnt_d;
    logic               core_reset_d, running_d, done_d, halted_d, timed_out_d;

    // State and registered outputs; reset returns to the start of the hold phase.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= RST_HOLD;
            hold_cnt   <= '0;
            stall_cnt  <= '0;
            pc_prev    <= '0;
            pc_valid   <= 1'b0;
            cycle_cnt  <= '0;
            core_reset <= 1'b1;
            running    <= 1'b0;
            done       <= 1'b0;
            halted     <= 1'b0;
            timed_out  <= 1'b0;
        end else begin
            state      <= state_d;
            hold_cnt   <= hold_cnt_d;
            stall_cnt  <= stall_cnt_d;
            pc_prev    <= pc_prev_d;
            pc_valid   <= pc_valid_d;
            cycle_cnt  <= cycle_cnt_d;
            core_reset <= core_reset_d;
            running    <= running_d;
            done       <= done_d;
            halted     <= halted_d;
            timed_out  <= timed_out_d;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d      = state;
        hold_cnt_d   = hold_cnt;
        stall_cnt_d  = stall_cnt;
        pc_prev_d    = pc_prev;
        pc_valid_d   = pc_valid;
        cycle_cnt_d  = cycle_cnt;
        core_reset_d = core_reset;
        running_d    = running;
        done_d       = done;
        halted_d     = halted;
        timed_out_d  = timed_out;

        case (state)
            RST_HOLD: begin
                core_reset_d = 1'b1;
                if (hold_cnt == HOLD_LAST) begin
                    state_d      = RUN;
                    hold_cnt_d   = '0;
                    core_reset_d = 1'b0;
                    running_d    = 1'b1;
                end else begin
                    hold_cnt_d = hold_cnt + HOLD_W'(1);
                end
            end

            RUN: begin
                cycle_cnt_d = cycle_cnt + CNT_W'(1);
                if (pc_valid && (pc_i == pc_prev)) begin
                    stall_cnt_d = stall_cnt + STALL_W'(1);
                end else begin
                    stall_cnt_d = '0;
                end
                pc_prev_d  = pc_i;
                pc_valid_d = 1'b1;
                // Halt wins over timeout when both land on the same edge.
                if (stall_cnt_d == STALL_LAST) begin
                    state_d   = DONE;
                    running_d = 1'b0;
                    done_d    = 1'b1;
                    halted_d  = 1'b1;
                end else if (cycle_cnt_d == CYC_LAST) begin
                    state_d     = DONE;
                    running_d   = 1'b0;
                    done_d      = 1'b1;
                    timed_out_d = 1'b1;
                end
            end

            DONE: begin
                core_reset_d = 1'b0;
                running_d    = 1'b0;
                done_d       = 1'b1;
                if (start) begin
                    state_d      = RST_HOLD;
                    hold_cnt_d   = '0;
                    cycle_cnt_d  = '0;
                    stall_cnt_d  = '0;
                    pc_valid_d   = 1'b0;
                    core_reset_d = 1'b1;
                    done_d       = 1'b0;
                    halted_d     = 1'b0;
                    timed_out_d  = 1'b0;
                end
            end

            default: begin
                state_d      = RST_HOLD;
                hold_cnt_d   = '0;
                core_reset_d = 1'b1;
                running_d    = 1'b0;
                done_d       = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_mips_run_ctrl.sv
// Directed bench for mips_run_ctrl: vector table for reset/halt/restart, plus
// hand sequences for timeout, held start, mid-run reset and halt/timeout collision.
module tb_mips_run_ctrl;

    localparam int unsigned PC_W = 32;
    localparam int unsigned CNT_W = 32;

    logic            clk;
    logic            reset;
    logic            start;
    logic [PC_W-1:0] pc_i;

    logic             core_reset1, running1, done1, halted1, timed_out1;
    logic [CNT_W-1:0] cycle_cnt1;
    logic             core_reset2, running2, done2, halted2, timed_out2;
    logic [CNT_W-1:0] cycle_cnt2;

    logic [4:0] flags1, flags2;
    assign flags1 = {core_reset1, running1, done1, halted1, timed_out1};
    assign flags2 = {core_reset2, running2, done2, halted2, timed_out2};

    int n_chk;
    int n_fail;

    mips_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(3), .MAX_CYCLES(20), .STALL_LIMIT(4)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .pc_i(pc_i),
        .core_reset(core_reset1), .running(running1), .done(done1),
        .halted(halted1), .timed_out(timed_out1), .cycle_cnt(cycle_cnt1)
    );

    // Short budget so halt and timeout coincide.
    mips_run_ctrl #(
        .PC_W(PC_W), .CNT_W(CNT_W), .RST_CYCLES(3), .MAX_CYCLES(5), .STALL_LIMIT(4)
    ) dut_sim (
        .clk(clk), .reset(reset), .start(start), .pc_i(pc_i),
        .core_reset(core_reset2), .running(running2), .done(done2),
        .halted(halted2), .timed_out(timed_out2), .cycle_cnt(cycle_cnt2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // flags = {core_reset, running, done, halted, timed_out}
    typedef struct {
        logic        rst;
        logic        st;
        logic [31:0] pc;
        logic [4:0]  flags;
        logic [31:0] cnt;
    } vec_t;

    vec_t vecs[20];

    function automatic vec_t mk(input logic r, input logic s, input logic [31:0] p,
                                input logic [4:0] f, input logic [31:0] c);
        vec_t v;
        v.rst = r; v.st = s; v.pc = p; v.flags = f; v.cnt = c;
        return v;
    endfunction

    task automatic step(input logic r, input logic s, input logic [31:0] p);
        @(negedge clk);
        reset = r;
        start = s;
        pc_i  = p;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    initial begin
        n_chk  = 0;
        n_fail = 0;
        reset  = 1'b0;
        start  = 1'b0;
        pc_i   = '0;

        // Reset hold, halt detect, restart.
        vecs[0]  = mk(1'b0, 1'b0, 32'h0,    5'b10000, 32'd0);
        vecs[1]  = mk(1'b0, 1'b0, 32'h0,    5'b10000, 32'd0);
        vecs[2]  = mk(1'b1, 1'b0, 32'h0,    5'b10000, 32'd0);
        vecs[3]  = mk(1'b1, 1'b0, 32'h0,    5'b10000, 32'd0);
        vecs[4]  = mk(1'b1, 1'b0, 32'h0,    5'b01000, 32'd0);
        for (int i = 5; i <= 10; i++)
            vecs[i] = mk(1'b1, 1'b0, 32'h3000 + 32'(4 * (i - 5)), 5'b01000, 32'(i - 4));
        vecs[11] = mk(1'b1, 1'b0, 32'h3014, 5'b01000, 32'd7);
        vecs[12] = mk(1'b1, 1'b0, 32'h3014, 5'b01000, 32'd8);
        vecs[13] = mk(1'b1, 1'b0, 32'h3014, 5'b01000, 32'd9);
        vecs[14] = mk(1'b1, 1'b0, 32'h3014, 5'b00110, 32'd10);
        vecs[15] = mk(1'b1, 1'b0, 32'h3014, 5'b00110, 32'd10);
        vecs[16] = mk(1'b1, 1'b1, 32'h3014, 5'b10000, 32'd0);
        vecs[17] = mk(1'b1, 1'b0, 32'h3014, 5'b10000, 32'd0);
        vecs[18] = mk(1'b1, 1'b0, 32'h3014, 5'b10000, 32'd0);
        vecs[19] = mk(1'b1, 1'b0, 32'h3014, 5'b01000, 32'd0);

        for (int i = 0; i < 20; i++) begin
            step(vecs[i].rst, vecs[i].st, vecs[i].pc);
            chk($sformatf("vec%0d flags", i), 32'(flags1), 32'(vecs[i].flags));
            chk($sformatf("vec%0d cycle_cnt", i), cycle_cnt1, vecs[i].cnt);
        end

        // Timeout: changing PC, start pulses during RUN ignored.
        for (int k = 0; k < 20; k++) begin
            step(1'b1, (k == 3 || k == 10), 32'h4000 + 32'(4 * k));
            if (k < 19) begin
                chk($sformatf("timeout run%0d flags", k), 32'(flags1), 32'(5'b01000));
                chk($sformatf("timeout run%0d cycle_cnt", k), cycle_cnt1, 32'(k + 1));
            end else begin
                chk("timeout done flags", 32'(flags1), 32'(5'b00101));
                chk("timeout done cycle_cnt", cycle_cnt1, 32'd20);
            end
        end
        step(1'b1, 1'b0, 32'h5000);
        chk("timeout hold flags", 32'(flags1), 32'(5'b00101));
        chk("timeout hold cycle_cnt", cycle_cnt1, 32'd20);

        // start held high for 5 cycles in DONE: exactly one restart.
        for (int j = 1; j <= 5; j++) begin
            step(1'b1, 1'b1, 32'h6000 + 32'(4 * j));
            if (j <= 3)
                chk($sformatf("held start %0d flags", j), 32'(flags1), 32'(5'b10000));
            else
                chk($sformatf("held start %0d flags", j), 32'(flags1), 32'(5'b01000));
            chk($sformatf("held start %0d cycle_cnt", j), cycle_cnt1, (j == 5) ? 32'd1 : 32'd0);
        end

        // Run to RUN cycle 7, then reset mid-run.
        for (int k = 1; k <= 6; k++) begin
            step(1'b1, 1'b0, 32'h7000 + 32'(4 * k));
        end
        chk("pre-reset cycle_cnt", cycle_cnt1, 32'd7);
        step(1'b0, 1'b0, 32'h7100);
        chk("midrun reset flags", 32'(flags1), 32'(5'b10000));
        chk("midrun reset cycle_cnt", cycle_cnt1, 32'd0);
        for (int j = 1; j <= 3; j++) begin
            step(1'b1, 1'b0, 32'h7200);
            chk($sformatf("rehold %0d flags", j), 32'(flags1), (j == 3) ? 32'(5'b01000) : 32'(5'b10000));
        end

        // Both instances just entered RUN; constant PC collides halt with timeout on dut_sim.
        for (int e = 1; e <= 5; e++) begin
            step(1'b1, 1'b0, 32'h3000);
            if (e < 5)
                chk($sformatf("simul run%0d flags", e), 32'(flags2), 32'(5'b01000));
            else
                chk("simul done flags", 32'(flags2), 32'(5'b00110));
            chk($sformatf("simul %0d cycle_cnt", e), cycle_cnt2, 32'(e));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/mips_run_ctrl.md
Name: mips_run_ctrl

Overview:
- Parametrised run controller for the pipelined mips core in simulation and FPGA bring-up.
- Stretches the board/bench reset into a core reset held for a configurable number of cycles.
- Counts run cycles and detects program end: either the PC is unchanged for STALL_LIMIT consecutive cycles (end-of-program dead loop) or MAX_CYCLES elapses (timeout). Reports done/halted/timed_out.
- Supports restart without external reset.

Parameters:
- PC_W, 32, width of monitored PC.
- CNT_W, 32, width of cycle counter; MAX_CYCLES must be < 2^CNT_W.
- RST_CYCLES, 2, cycles core_reset stays high after reset release or restart; >=1.
- MAX_CYCLES, 100000, RUN-cycle budget before timeout; >=1.
- STALL_LIMIT, 16, consecutive unchanged-PC cycles declaring halt; >=1.

Ports:
- clk  input  1  sole clock, rising edge.
- reset  input  1  synchronous, active-low reset (0 = reset).
- start  input  1  restart pulse; honoured only in DONE.
- pc_i  input  PC_W  current PC from core (F or W stage, integrator's choice).
- core_reset  output  1  active-high reset to mips core.
- running  output  1  high in RUN.
- done  output  1  high in DONE.
- halted  output  1  DONE entered by PC-stall detection.
- timed_out  output  1  DONE entered by cycle budget.
- cycle_cnt  output  CNT_W  RUN cycles elapsed; frozen in DONE.

Behaviour:
- All outputs registered. States: RST_HOLD, RUN, DONE.
- reset==0 at an edge: state=RST_HOLD, hold_cnt=0, cycle_cnt=0, stall_cnt=0, pc_valid=0, core_reset=1, running=0, done=0, halted=0, timed_out=0. Takes effect at any state, including mid-RUN.
- RST_HOLD: core_reset=1. Each edge with reset==1 increments hold_cnt. On the edge where hold_cnt==RST_CYCLES-1, go to RUN (core_reset=0, running=1). core_reset is therefore high for exactly RST_CYCLES cycles after reset release.
- RUN, each edge:
  - cycle_cnt += 1.
  - If pc_valid and pc_i==pc_prev, stall_cnt += 1; else stall_cnt=0.
  - pc_prev=pc_i; pc_valid=1. The first RUN cycle never counts as a stall.
  - If the new stall_cnt==STALL_LIMIT, go to DONE with halted=1.
  - Else if the new cycle_cnt==MAX_CYCLES, go to DONE with timed_out=1.
  - Both on the same edge: halted=1, timed_out=0 (halt has priority).
- DONE: running=0, done=1, core_reset=0. Core is not reset; freezing the core is the harness's job. cycle_cnt, halted and timed_out hold.
  - start==1 enters RST_HOLD next edge: hold_cnt, cycle_cnt, stall_cnt, pc_valid, done, halted and timed_out all cleared; core_reset=1.
- start is ignored in RST_HOLD and RUN. start is level-sampled; holding it high in DONE restarts only once, because the state leaves DONE.
- cycle_cnt never wraps: the timeout fires at MAX_CYCLES first.
- No X on outputs after the first reset edge.

Test Plan:
All tests use PC_W=32, RST_CYCLES=3, MAX_CYCLES=20, STALL_LIMIT=4 unless noted.
- Reset hold: reset=0 for 2 edges, then 1 -> core_reset=1 and running=0 for 3 cycles after release; on the 4th cycle running=1, core_reset=0, cycle_cnt=0.
- Halt detect: pc_i=0x3000+4k in RUN cycles k=0..5, then held at 0x3014 -> DONE after RUN cycle 9; halted=1, timed_out=0, cycle_cnt=10.
- Timeout: pc_i changes every cycle -> DONE after 20 RUN cycles; timed_out=1, halted=0, cycle_cnt=20. start pulses during RUN have no effect.
- Simultaneous (MAX_CYCLES=5): pc_i constant 0x3000 from RUN start -> stall reaches 4 and cycle_cnt reaches 5 on the same edge; halted=1, timed_out=0, cycle_cnt=5.
- Restart: in DONE, pulse start for 1 cycle -> next cycle core_reset=1, done=0, flags 0, cycle_cnt=0; RUN resumes 3 cycles later. Holding start high for 5 cycles in DONE gives a single restart.
- Reset mid-run: reset=0 at RUN cycle 7 -> next edge core_reset=1, running=0, cycle_cnt=0; after release the full 3-cycle hold is repeated.
